// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Handshaked, parametrised arithmetic unit. It accepts one operation at a
//   time over a valid/ready request channel. ADD, SUB (magnitude plus sign
//   flag) and AND finish on the accept edge. MUL runs a sequential shift-add
//   engine, one multiplier bit per clock. The 2*WIDTH-bit result is held in a
//   register and returned over a valid/ready result channel.
//
// Build option
//   SEQ_ALU_EARLY_TERM_EN : when defined, MUL stops as soon as the remaining
//                           multiplier bits are all zero. The product is the
//                           same; only the latency shrinks.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous, active-low reset
//   in_valid     operation request valid
//   in_ready     block can accept an operation (high only in IDLE)
//   op           opcode: 00 ADD, 01 SUB, 10 MUL, 11 AND
//   a, b         unsigned WIDTH-bit operands
//   out_valid    result valid (registered)
//   out_ready    consumer accepts the result
//   result       2*WIDTH-bit result, zero-extended (registered)
//   is_negative  SUB only: set when a < b (registered)
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 is_negative
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t               state_r, state_s;
   logic [2*WIDTH-1:0]   result_r, result_s;
   logic                 is_negative_r, is_negative_s;
   logic                 out_valid_r, out_valid_s;
   logic [2*WIDTH-1:0]   acc_r, acc_s;
   logic [2*WIDTH-1:0]   mcand_r, mcand_s;
   logic [WIDTH-1:0]     mplier_r, mplier_s;
   logic [CW-1:0]        cnt_r, cnt_s;

   logic [WIDTH:0]       sum_s;
   logic                 a_ge_b_s;
   logic [WIDTH-1:0]     diff_s;
   logic [WIDTH-1:0]     and_s;
   logic [2*WIDTH-1:0]   acc_step_s;
   logic [WIDTH-1:0]     mplier_shift_s;
   logic                 mul_last_s;

   // Datapath for the single-cycle ops, taken straight from the operand inputs.
   assign sum_s    = {1'b0, a} + {1'b0, b};
   assign a_ge_b_s = (a >= b);
   assign diff_s   = a_ge_b_s ? (a - b) : (b - a);
   assign and_s    = a & b;

   // One shift-add step; the multiplicand register is pre-shifted so that it
   // always carries the weight of the current multiplier LSB.
   assign acc_step_s     = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
   assign mplier_shift_s = mplier_r >> 1;

`ifdef SEQ_ALU_EARLY_TERM_EN
   // Stop once no set multiplier bits remain; the counter still bounds the run.
   assign mul_last_s = (cnt_r == CW'(WIDTH - 1)) || (mplier_shift_s == {WIDTH{1'b0}});
`else
   assign mul_last_s = (cnt_r == CW'(WIDTH - 1));
`endif

   // in_ready depends only on the state register.
   assign in_ready    = (state_r == IDLE);
   assign out_valid   = out_valid_r;
   assign result      = result_r;
   assign is_negative = is_negative_r;

   // Next-state and next-register computation for the control FSM and datapath.
   always_comb begin
      state_s       = state_r;
      result_s      = result_r;
      is_negative_s = is_negative_r;
      out_valid_s   = out_valid_r;
      acc_s         = acc_r;
      mcand_s       = mcand_r;
      mplier_s      = mplier_r;
      cnt_s         = cnt_r;

      case (state_r)
         IDLE: begin
            if (in_valid) begin
               case (op)
                  OP_ADD: begin
                     result_s      = {{(WIDTH-1){1'b0}}, sum_s};
                     is_negative_s = 1'b0;
                     out_valid_s   = 1'b1;
                     state_s       = DONE;
                  end
                  OP_SUB: begin
                     result_s      = {{WIDTH{1'b0}}, diff_s};
                     is_negative_s = ~a_ge_b_s;
                     out_valid_s   = 1'b1;
                     state_s       = DONE;
                  end
                  OP_AND: begin
                     result_s      = {{WIDTH{1'b0}}, and_s};
                     is_negative_s = 1'b0;
                     out_valid_s   = 1'b1;
                     state_s       = DONE;
                  end
                  OP_MUL: begin
                     acc_s    = {(2*WIDTH){1'b0}};
                     mcand_s  = {{WIDTH{1'b0}}, a};
                     mplier_s = b;
                     cnt_s    = {CW{1'b0}};
                     state_s  = MUL;
                  end
                  default: begin
                     state_s = IDLE;
                  end
               endcase
            end else begin
               state_s = IDLE;
            end
         end

         MUL: begin
            acc_s    = acc_step_s;
            mcand_s  = mcand_r << 1;
            mplier_s = mplier_shift_s;
            cnt_s    = cnt_r + CW'(1);
            if (mul_last_s) begin
               result_s      = acc_step_s;
               is_negative_s = 1'b0;
               out_valid_s   = 1'b1;
               state_s       = DONE;
            end else begin
               state_s = MUL;
            end
         end

         DONE: begin
            // A result drain never coincides with a new accept: in_ready is
            // low here, so the next operation waits for IDLE.
            if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = IDLE;
            end else begin
               state_s = DONE;
            end
         end

         default: begin
            out_valid_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
   end

   // State, result and multiplier registers; reset discards any in-flight op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         result_r      <= {(2*WIDTH){1'b0}};
         is_negative_r <= 1'b0;
         out_valid_r   <= 1'b0;
         acc_r         <= {(2*WIDTH){1'b0}};
         mcand_r       <= {(2*WIDTH){1'b0}};
         mplier_r      <= {WIDTH{1'b0}};
         cnt_r         <= {CW{1'b0}};
      end else begin
         state_r       <= state_s;
         result_r      <= result_s;
         is_negative_r <= is_negative_s;
         out_valid_r   <= out_valid_s;
         acc_r         <= acc_s;
         mcand_r       <= mcand_s;
         mplier_r      <= mplier_s;
         cnt_r         <= cnt_s;
      end
   end

endmodule
